// File: rtl/gsensor_pkg.sv
// Shared definitions for the G-sensor axis filters: output width, output
// saturation limits and the filter state enumeration.
package gsensor_pkg;

  localparam int DIG_W   = 10;
  localparam int DIG_MAX = 511;
  localparam int DIG_MIN = -512;

  typedef enum logic {
    EMPTY = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/gsensor_avg_filter_if.sv
// Sample/result bundle between the SPI reader, the averaging filter and the
// 7-segment driver. The filter itself is the slave side.
interface gsensor_avg_filter_if;
  import gsensor_pkg::*;

  logic [15:0]      iDATA;
  logic             iVALID;
  logic             iCLR;
  logic [DIG_W-1:0] oDIG;
  logic             oVALID;
  logic             oSTALE;

  modport master (
    output iDATA, iVALID, iCLR,
    input  oDIG, oVALID, oSTALE
  );

  modport slave (
    input  iDATA, iVALID, iCLR,
    output oDIG, oVALID, oSTALE
  );

endinterface

// File: rtl/gsensor_sat.sv
// Clamps a raw signed 16-bit axis sample into the signed 10-bit display range.
module gsensor_sat
  import gsensor_pkg::*;
(
  input  logic signed [15:0]      i_data,
  output logic signed [DIG_W-1:0] o_data
);

  localparam logic signed [15:0] MAX16 = 16'(DIG_MAX);
  localparam logic signed [15:0] MIN16 = 16'(DIG_MIN);

  // Pick the clamp limit or pass the low bits straight through when in range.
  always_comb begin
    o_data = i_data[DIG_W-1:0];
    if (i_data > MAX16) begin
      o_data = DIG_W'(DIG_MAX);
    end else if (i_data < MIN16) begin
      o_data = DIG_W'(DIG_MIN);
    end
  end

endmodule

// File: rtl/gsensor_avg_filter.sv
// Moving-average filter for one accelerometer axis. Keeps a window of the
// last 2**DEPTH_LOG2 saturated samples and a running sum, and drops back to
// EMPTY (stale) after TIMEOUT idle cycles or on an explicit clear.
module gsensor_avg_filter
  import gsensor_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int TIMEOUT    = 5000000
) (
  input  logic                iCLK,
  input  logic                iRSTN,
  gsensor_avg_filter_if.slave bus
);

  localparam int N      = 1 << DEPTH_LOG2;
  localparam int SUM_W  = DIG_W + DEPTH_LOG2;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  state_t                  r_state;
  logic signed [DIG_W-1:0] r_buf [N];
  logic [DEPTH_LOG2-1:0]   r_ptr;
  logic signed [SUM_W-1:0] r_sum;
  logic [IDLE_W-1:0]       r_idle;
  logic signed [DIG_W-1:0] r_dig;
  logic                    r_valid;
  logic                    r_stale;

  logic signed [DIG_W-1:0] w_sample;
  logic signed [SUM_W-1:0] w_sumNext;
  logic [IDLE_W-1:0]       w_idleNext;
  logic                    w_expire;

  gsensor_sat u_sat (
    .i_data (bus.iDATA),
    .o_data (w_sample)
  );

  // Next running sum: a fresh window is N copies of the sample, otherwise
  // the new sample replaces the oldest one in the sum.
  always_comb begin
    w_sumNext = r_sum;
    if (r_state == EMPTY) begin
      w_sumNext = SUM_W'(w_sample) <<< DEPTH_LOG2;
    end else begin
      w_sumNext = r_sum + SUM_W'(w_sample) - SUM_W'(r_buf[r_ptr]);
    end
  end

  // Idle counter saturates at TIMEOUT; expiry is the cycle it gets there.
  always_comb begin
    w_idleNext = (r_idle == IDLE_MAX) ? r_idle : r_idle + 1'b1;
    w_expire   = (r_state == RUN) && (w_idleNext == IDLE_MAX);
  end

  // Filter state machine with registered outputs; clear beats a sample,
  // a sample beats the idle timeout.
  always_ff @(posedge iCLK) begin
    if (!iRSTN) begin
      r_state <= EMPTY;
      r_ptr   <= '0;
      r_sum   <= '0;
      r_idle  <= '0;
      r_dig   <= '0;
      r_valid <= 1'b0;
      r_stale <= 1'b1;
      for (int i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      if (bus.iCLR) begin
        r_state <= EMPTY;
        r_stale <= 1'b1;
        r_sum   <= '0;
        r_ptr   <= '0;
        r_idle  <= w_idleNext;
        for (int i = 0; i < N; i++) begin
          r_buf[i] <= '0;
        end
      end else if (bus.iVALID) begin
        r_state <= RUN;
        r_stale <= 1'b0;
        r_valid <= 1'b1;
        r_idle  <= '0;
        r_sum   <= w_sumNext;
        r_dig   <= DIG_W'(w_sumNext >>> DEPTH_LOG2);
        if (r_state == EMPTY) begin
          for (int i = 0; i < N; i++) begin
            r_buf[i] <= w_sample;
          end
        end else begin
          r_buf[r_ptr] <= w_sample;
          r_ptr        <= r_ptr + 1'b1;
        end
      end else begin
        r_idle <= w_idleNext;
        if (w_expire) begin
          r_state <= EMPTY;
          r_stale <= 1'b1;
        end
      end
    end
  end

  assign bus.oDIG   = r_dig;
  assign bus.oVALID = r_valid;
  assign bus.oSTALE = r_stale;

endmodule

// File: tb/tb_gsensor_avg_filter.sv
// Bench for the axis averaging filter: directed scenarios followed by random
// traffic, with results checked against a window-of-samples model through a
// scoreboard queue.
module tb_gsensor_avg_filter;
  import gsensor_pkg::*;

  localparam int DL2 = 3;
  localparam int N   = 1 << DL2;
  localparam int TO  = 20;

  typedef struct {
    int dig;
    int cyc;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  gsensor_avg_filter_if bus();

  gsensor_avg_filter #(
    .DEPTH_LOG2 (DL2),
    .TIMEOUT    (TO)
  ) dut (
    .iCLK  (clk),
    .iRSTN (rstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t expQ [$];
  int   win  [$];
  bit   mEmpty     = 1'b1;
  bit   mLastValid = 1'b0;
  int   mIdle      = 0;
  int   lastDig    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int satRef(input int v);
    if (v > DIG_MAX) return DIG_MAX;
    if (v < DIG_MIN) return DIG_MIN;
    return v;
  endfunction

  function automatic int floorDiv(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int digInt();
    return int'($signed(bus.oDIG));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model reflects what the window should hold
  // after that edge and queues the expected result of any sample.
  task automatic applyStimulus(input bit v, input bit c, input int data);
    exp_t        e;
    logic [15:0] d16;
    int          s;
    int          sum;
    d16        = 16'(data);
    bus.iVALID = v;
    bus.iCLR   = c;
    bus.iDATA  = d16;
    mLastValid = v && !c;
    if (c) begin
      mEmpty = 1'b1;
      win.delete();
      mIdle++;
    end else if (v) begin
      s = satRef(int'($signed(d16)));
      if (mEmpty) begin
        win.delete();
        repeat (N) win.push_back(s);
      end else begin
        void'(win.pop_front());
        win.push_back(s);
      end
      sum = 0;
      foreach (win[i]) sum += win[i];
      lastDig = floorDiv(sum, N);
      mEmpty  = 1'b0;
      mIdle   = 0;
      e.dig   = lastDig;
      e.cyc   = cyc + 1;
      expQ.push_back(e);
    end else begin
      mIdle++;
      if (mIdle >= TO) mEmpty = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.iVALID = 1'b0;
    bus.iCLR   = 1'b0;
  endtask

  // Holds reset for a number of edges, optionally with a sample offered
  // at the same time, which must be thrown away.
  task automatic applyReset(input int cycles, input bit v, input int data);
    rstn       = 1'b0;
    bus.iVALID = v;
    bus.iCLR   = 1'b0;
    bus.iDATA  = 16'(data);
    repeat (cycles) @(posedge clk);
    #1;
    rstn       = 1'b1;
    bus.iVALID = 1'b0;
    mEmpty     = 1'b1;
    mLastValid = 1'b0;
    mIdle      = 0;
    lastDig    = 0;
    win.delete();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_dig"},   digInt(), lastDig);
    check({tag, "_stale"}, int'(bus.oSTALE), int'(mEmpty));
    check({tag, "_valid"}, int'(bus.oVALID), int'(mLastValid));
  endtask

  function automatic int randData();
    int pick [6];
    pick = '{511, 512, -512, -513, 32767, -32768};
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 1200)) - 600;
      1:       return int'($signed(16'($urandom)));
      2:       return pick[$urandom_range(0, 5)];
      default: return int'($urandom_range(0, 40)) - 20;
    endcase
  endfunction

  // Scoreboard monitor: every output pulse must match the oldest queued
  // expectation, in value and in the cycle it was due.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.oVALID === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_ovalid actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = expQ.pop_front();
        check("sb_dig",     digInt(), e.dig);
        check("sb_latency", cyc, e.cyc);
        check("sb_stale",   int'(bus.oSTALE), 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bus.iVALID = 1'b0;
    bus.iCLR   = 1'b0;
    bus.iDATA  = '0;

    applyReset(3, 1'b0, 0);
    check("reset_dig",   digInt(), 0);
    check("reset_stale", int'(bus.oSTALE), 1);
    check("reset_valid", int'(bus.oVALID), 0);

    // First sample after reset preloads the window.
    applyStimulus(1'b1, 1'b0, 100);
    check("first_dig", digInt(), 100);
    checkOutput("first");

    // Ramp from a zero window towards +80.
    applyStimulus(1'b0, 1'b1, 0);
    checkOutput("clr");
    applyStimulus(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 80);
      check("ramp", digInt(), 10 * (i + 1));
    end

    // Floor toward minus infinity: (-7 - 2) / 8 -> -2.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, -1);
    applyStimulus(1'b1, 1'b0, -2);
    check("neg_floor", digInt(), -2);

    // Saturation at both ends.
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 'h7FFF);
    check("sat_7fff", digInt(), 511);
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 'h8000);
    check("sat_8000", digInt(), -512);
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 'h0300);
    check("sat_0300", digInt(), 511);
    applyStimulus(1'b0, 1'b1, 0);
    applyStimulus(1'b1, 1'b0, 'hFC00);
    check("sat_fc00", digInt(), -512);

    // A sample arriving exactly at the timeout keeps the window alive.
    repeat (TO - 1) applyStimulus(1'b0, 1'b0, 0);
    checkOutput("pre_timeout");
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("at_timeout");
    check("at_timeout_dig", digInt(), -448);

    // Full timeout: stale, value held, next sample preloads.
    repeat (TO) applyStimulus(1'b0, 1'b0, 0);
    checkOutput("timeout");
    check("timeout_stale", int'(bus.oSTALE), 1);
    applyStimulus(1'b1, 1'b0, 7);
    check("after_timeout_dig", digInt(), 7);

    // Clear and sample together: the clear wins.
    applyStimulus(1'b1, 1'b1, 55);
    checkOutput("clr_valid");
    check("clr_valid_stale", int'(bus.oSTALE), 1);
    applyStimulus(1'b1, 1'b0, -30);
    check("after_clr_dig", digInt(), -30);

    // Reset in the middle of traffic discards the sample on that edge.
    applyStimulus(1'b1, 1'b0, 200);
    applyReset(1, 1'b1, 300);
    checkOutput("mid_reset");
    applyStimulus(1'b1, 1'b0, 40);
    check("after_reset_dig", digInt(), 40);

    // Random traffic.
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        applyStimulus(1'b1, 1'b1, randData());
      end else if (r < 6) begin
        repeat ($urandom_range(15, 25)) applyStimulus(1'b0, 1'b0, 0);
      end else if (r < 65) begin
        applyStimulus(1'b1, 1'b0, randData());
      end else begin
        applyStimulus(1'b0, 1'b0, 0);
      end
      if ((it % 16) == 15) checkOutput("rand");
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 0);
    check("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gsensor_avg_filter.md
GSENSOR_AVG_FILTER -- requirements
Module: gsensor_avg_filter

Interface
REQ-001 Parameter: DEPTH_LOG2, default 3; window length N = 2**DEPTH_LOG2 samples, legal range 1..4.
REQ-002 Parameter: TIMEOUT, default 5000000; idle iCLK cycles without a sample before the block declares data stale (100 ms at 50 MHz).
REQ-003 iCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 iRSTN  input  1  synchronous active-low reset.
REQ-005 iDATA  input  16  raw axis sample from the SPI reader, signed two's complement.
REQ-006 iVALID  input  1  one-cycle strobe; iDATA is valid in that cycle.
REQ-007 iCLR  input  1  synchronous flush of the window.
REQ-008 oDIG  output  10  filtered axis value, signed two's complement; feeds the 7-segment driver's iDIG input.
REQ-009 oVALID  output  1  one-cycle pulse when oDIG updates.
REQ-010 oSTALE  output  1  high while no fresh data is present (empty or timed out).

Function
REQ-011 Each accepted sample is saturated to the signed 10-bit range [-512, +511] before use; e.g. 16'h0300 -> +511, 16'hFC00 -> -512.
REQ-012 The block has two states: EMPTY and RUN.
REQ-013 In EMPTY, the first iVALID preloads all N buffer entries with the saturated sample, sets sum = N*sample, and moves the state to RUN.
REQ-014 In RUN, each iVALID overwrites the oldest entry (circular write pointer, wraps N-1 -> 0) and sets sum <= sum + new - oldest.
REQ-015 The sum register is signed, 10 + DEPTH_LOG2 bits wide, and never overflows by construction.
REQ-016 oDIG = sum >>> DEPTH_LOG2 (arithmetic shift, floor toward -inf), taken from the post-update sum.
REQ-017 Latency: oDIG and oVALID update in the cycle after the iVALID cycle; oVALID is high for exactly one cycle per accepted sample.
REQ-018 oDIG holds its value between updates.
REQ-019 Back-to-back iVALID on consecutive cycles is accepted at full rate with no lost samples.
REQ-020 Idle counter: clears on every iVALID, increments otherwise, and saturates at TIMEOUT.
REQ-021 Timeout: when the idle counter reaches TIMEOUT in RUN, the state returns to EMPTY and oSTALE is set; oDIG keeps its last value and no oVALID is issued.
REQ-022 oSTALE is high in EMPTY and low in RUN; it falls in the same cycle as the oVALID of the first sample after EMPTY.
REQ-023 iCLR returns the state to EMPTY, zeroes the buffer, sum and write pointer, and leaves oDIG unchanged; no oVALID is issued.
REQ-024 iCLR and iVALID in the same cycle: the clear wins and the sample is discarded.
REQ-025 iVALID in the same cycle as the timeout expiry: the sample wins, the state stays in RUN, and the counter clears.

Reset
REQ-026 While iRSTN is low at a clock edge: state = EMPTY, buffer = 0, sum = 0, pointer = 0, idle counter = 0, oDIG = 0, oVALID = 0, oSTALE = 1.
REQ-027 Reset asserted mid-operation aborts any update in that cycle; the first iVALID after reset release is treated as a preload per REQ-013.

Structure
REQ-028 Shared package gsensor_pkg holds: DIG_W = 10, DIG_MAX = 511, DIG_MIN = -512, and the state enumeration {EMPTY, RUN}.
REQ-029 Saturation is implemented in one combinational sub-module, gsensor_sat (16-bit signed in, 10-bit signed out), reusable by the other axes.
REQ-030 Buffer is a register array of N x 10 bits; no RAM inference is required.

Verification
REQ-031 Reset, then one iVALID with iDATA = 16'd100 -> one cycle later oDIG = 100, oVALID pulse, oSTALE 1 -> 0.
REQ-032 From a window preloaded with 0, feed eight samples of +80 -> oDIG sequence 10, 20, 30, 40, 50, 60, 70, 80.
REQ-033 Negative floor: window preloaded with -1, then one sample of -2 -> sum = -9, oDIG = -2 (10'h3FE).
REQ-034 Saturation: iDATA = 16'h7FFF -> oDIG = 511; iDATA = 16'h8000 -> oDIG = -512 (10'h200).
REQ-035 Timeout, run with TIMEOUT = 20: no iVALID for 20 cycles -> oSTALE = 1 and oDIG held; next sample of 7 -> oDIG = 7 (preload).
REQ-036 iCLR and iVALID in the same cycle -> no oVALID and oSTALE = 1; the next iVALID preloads.
